button_chord_encoder: RTL and testbench
=======================================

// Module: button_chord_encoder
// PURPOSE
//  Front end for the 4-bit button command bus consumed by the channel-strip control decoder.
//  - Synchronises and debounces the four raw active-low pushbuttons.
//  - Collects a chord: the OR of all keys pressed while any key is held.
//  - On full release, drives the chord code for exactly one clk_48 cycle; buttons is 4'h0 at all other times.
//  - One cycle per command is required because the decoder acts on every cycle a non-zero code is present.
// PARAMETERS
//  DEBOUNCE_CYCLES  480_000     stable cycles before a key level is accepted (10 ms at 48 MHz)
//  TIMEOUT_CYCLES   96_000_000  max chord duration before abort; used only with CHORD_TIMEOUT_EN
// PORTS
//  clk_48      in   1  48 MHz system clock; single clock domain
//  reset       in   1  synchronous, active-high reset
//  key_n       in   4  raw pushbuttons, active-low, asynchronous to clk_48
//  buttons     out  4  command code to decoder; 4'h0 = idle
//  code_valid  out  1  one-cycle strobe, high exactly when buttons != 0
//  busy        out  1  high while a chord is being collected or aborted
//  key_db      out  4  debounced key levels, active-high (1 = pressed)
// BEHAVIOUR
//  - Reset: buttons=0, code_valid=0, busy=0, key_db=0; sync flops=released; counters=0; FSM=IDLE; chord=0.
//  - Input path per key: 2-flop synchroniser, then invert.
//  - Debounce per key:
//    - Counter clears whenever the synced level equals key_db.
//    - On mismatch the counter increments; when it reaches DEBOUNCE_CYCLES-1, key_db flips and the counter clears.
//    - Latency from a clean input edge to key_db: 2 + DEBOUNCE_CYCLES cycles.
//    - A glitch shorter than DEBOUNCE_CYCLES never changes key_db.
//  - FSM states: IDLE, COLLECT, EMIT, ABORT.
//    - IDLE: key_db != 0 -> COLLECT, with chord <= key_db.
//    - COLLECT: chord <= chord | key_db every cycle; key_db == 0 -> EMIT.
//    - EMIT: lasts one cycle; buttons=chord, code_valid=1; chord cleared -> IDLE.
//    - Pressing a key in EMIT is ignored that cycle and starts a new chord from IDLE on the next cycle.
//  - busy = (state == COLLECT || state == ABORT); registered outputs, no combinational path from key_n.
//  - A chord is never empty in EMIT, so code 4'h0 is never strobed.
//  - Reset asserted mid-chord: the chord is discarded and nothing is emitted.
//  - Key held through reset release: seen as a press after the debounce latency, then handled normally.
//  - Widths: debounce counter $clog2(DEBOUNCE_CYCLES); timeout counter $clog2(TIMEOUT_CYCLES). Neither wraps; both saturate/clear as stated.
// CONFIGURATION
//  Macro CHORD_TIMEOUT_EN.
//  - Defined: a timeout counter runs in COLLECT. When it reaches TIMEOUT_CYCLES-1 -> ABORT.
//    - ABORT: nothing is emitted; waits until key_db == 0, then -> IDLE.
//    - The counter clears on every entry to COLLECT.
//  - Undefined: no ABORT state and no timeout counter; a chord of any length emits on release.
// STRUCTURE
//  - Package button_pkg:
//    - typedef logic [3:0] btn_code_t
//    - typedef enum {IDLE, COLLECT, EMIT, ABORT} chord_state_t
//    - localparams CODE_IDLE=4'h0, CODE_MUTE=4'h7
//  - Sub-module key_debounce: synchroniser + debounce for one key, DEBOUNCE_CYCLES parameter.
//    Instantiated 4x in a generate loop; the FSM lives in the top module.
// TESTING (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
//  1. key_n[0] low 20 cycles, then high -> one code_valid pulse with buttons=4'h1, one cycle after key_db[0] falls.
//  2. key_n[1] toggles every 2 cycles for 12 cycles, then held low 20, then high -> key_db[1] rises once, single 4'h2 emitted.
//  3. key_n[0], [1], [2] pressed 5 cycles apart, released 5 cycles apart -> exactly one emission, buttons=4'h7 (mute).
//  4. key_n[3] low for 3 cycles only -> key_db stays 0, busy stays 0, no code_valid.
//  5. key_n[3] held, reset pulsed 1 cycle in COLLECT, key held 10 more cycles then released ->
//     all outputs 0 after reset; with key_db[3]=0 from reset, the held key re-debounces, starts a new chord,
//     and one 4'h8 is emitted after release.
//  6. key_n[2] held 100 cycles then released -> with CHORD_TIMEOUT_EN: no emission, busy falls after release.
//     Without CHORD_TIMEOUT_EN: one 4'h4 emitted.

Source files
------------

// File: rtl/button_chord_encoder_pkg.sv
// Shared types and codes for the button chord encoder.
// Contents:
//   btn_code_t     - 4-bit command code on the decoder bus
//   chord_state_t  - chord collection FSM states
//   CODE_IDLE      - bus value when no command is present
//   CODE_MUTE      - chord of keys 0, 1 and 2
package button_pkg;

  typedef logic [3:0] btn_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    ABORT   = 2'd3
  } chord_state_t;

  localparam btn_code_t CODE_IDLE = 4'h0;
  localparam btn_code_t CODE_MUTE = 4'h7;

endpackage

// File: rtl/button_chord_encoder_key_debounce.sv
// key_debounce: synchroniser and debouncer for one active-low pushbutton.
// Ports:
//   clk_i     - 48 MHz system clock
//   rst_i     - synchronous active-high reset
//   key_n_i   - raw pushbutton, active-low, asynchronous to clk_i
//   key_db_o  - debounced level, active-high (1 = pressed)
// The debounced level flips only after the synchronised level has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 480_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic key_db_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Synchronised level converted to active-high.
  assign pressed = ~sync2_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (pressed != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db_o = db_q;

endmodule

// File: rtl/button_chord_encoder.sv
// button_chord_encoder: debounces four active-low pushbuttons, collects the
// OR of every key pressed while any key is held, and on full release puts the
// chord code on the decoder bus for exactly one cycle.
// Ports:
//   clk_48      - 48 MHz system clock, single domain
//   reset       - synchronous active-high reset
//   key_n       - raw pushbuttons, active-low, asynchronous
//   buttons     - command code to the decoder, 4'h0 when idle
//   code_valid  - one-cycle strobe, high exactly when buttons != 0
//   busy        - high while a chord is being collected or aborted
//   key_db      - debounced key levels, active-high
// Build option: define CHORD_TIMEOUT_EN to abort chords held longer than
// TIMEOUT_CYCLES; aborted chords emit nothing.
module button_chord_encoder
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 480_000,
  parameter int unsigned TIMEOUT_CYCLES  = 96_000_000
) (
  input  logic       clk_48,
  input  logic       reset,
  input  logic [3:0] key_n,
  output btn_code_t  buttons,
  output logic       code_valid,
  output logic       busy,
  output logic [3:0] key_db
);

  logic [3:0]   key_db_w;
  chord_state_t state_q;
  chord_state_t state_d;
  btn_code_t    chord_q;
  btn_code_t    chord_d;
  btn_code_t    buttons_q;
  btn_code_t    buttons_d;
  logic         valid_q;
  logic         valid_d;
  logic         busy_q;
  logic         busy_d;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_48),
      .rst_i   (reset),
      .key_n_i (key_n[k]),
      .key_db_o(key_db_w[k])
    );
  end

`ifdef CHORD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
`endif

  // Outputs are computed from the next state so they leave flops directly.
  always_comb begin
    state_d   = state_q;
    chord_d   = chord_q;
    buttons_d = CODE_IDLE;
    valid_d   = 1'b0;
`ifdef CHORD_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_db_w != CODE_IDLE) begin
          state_d = COLLECT;
          chord_d = key_db_w;
`ifdef CHORD_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      COLLECT: begin
        chord_d = chord_q | key_db_w;
        if (key_db_w == CODE_IDLE) begin
          // Chord entered COLLECT with a key down, so it cannot be empty here.
          state_d   = EMIT;
          buttons_d = chord_q;
          valid_d   = 1'b1;
        end
`ifdef CHORD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ABORT;
          chord_d = CODE_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      EMIT: begin
        // Keys seen this cycle are picked up from IDLE on the next one.
        state_d = IDLE;
        chord_d = CODE_IDLE;
      end
`ifdef CHORD_TIMEOUT_EN
      ABORT: begin
        if (key_db_w == CODE_IDLE) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        chord_d = CODE_IDLE;
      end
    endcase
    busy_d = (state_d == COLLECT) || (state_d == ABORT);
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_q   <= IDLE;
      chord_q   <= CODE_IDLE;
      buttons_q <= CODE_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CHORD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      chord_q   <= chord_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef CHORD_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign buttons    = buttons_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign key_db     = key_db_w;

endmodule

// File: tb/tb_button_chord_encoder.sv
module tb_button_chord_encoder;
  import button_pkg::*;

  localparam int D = 4;
  localparam int T = 50;
`ifdef CHORD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_n = 4'hF;
  btn_code_t  buttons;
  logic       code_valid;
  logic       busy;
  logic [3:0] key_db;

  button_chord_encoder #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_48    (clk),
    .reset     (reset),
    .key_n     (key_n),
    .buttons   (buttons),
    .code_valid(code_valid),
    .busy      (busy),
    .key_db    (key_db)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int npulse = 0;
  int rise1 = 0;
  logic [3:0] last_code = 4'h0;
  logic prev_db1 = 1'b0;
  bit chk_en = 1'b0;

  // ---------------- behavioural reference model ----------------
  // Each key: the debounced level flips once the last D synchronised
  // samples all disagree with it. Chords: OR of the debounced levels while
  // any is held, reported on the cycle after everything is released.
  logic [3:0]   m_raw1, m_raw2;   // raw samples 1 and 2 edges old
  logic [D-1:0] m_hist [4];
  logic [3:0]   m_db;
  bit           m_collecting, m_aborted, m_emit_now;
  logic [3:0]   m_chord, m_emit_code;
  int           m_age;
  logic [3:0]   e_buttons;
  logic         e_valid, e_busy;

  task automatic model_reset();
    m_raw1 = 4'hF; m_raw2 = 4'hF; m_db = 4'h0;
    for (int k = 0; k < 4; k++) m_hist[k] = '0;
    m_collecting = 0; m_aborted = 0; m_emit_now = 0;
    m_chord = 4'h0; m_emit_code = 4'h0; m_age = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      // chord tracking uses the debounced levels from before this edge
      if (m_emit_now) begin
        m_emit_now = 0;
      end else if (m_collecting) begin
        if (m_db == 4'h0) begin
          m_emit_now = 1; m_emit_code = m_chord; m_collecting = 0;
        end else if (TMO_EN && m_age == T - 1) begin
          m_collecting = 0; m_aborted = 1;
        end else begin
          m_chord = m_chord | m_db; m_age = m_age + 1;
        end
      end else if (m_aborted) begin
        if (m_db == 4'h0) m_aborted = 0;
      end else if (m_db != 4'h0) begin
        m_collecting = 1; m_chord = m_db; m_age = 0;
      end
      for (int k = 0; k < 4; k++) begin
        m_hist[k] = {m_hist[k][D-2:0], ~m_raw2[k]};
        if (m_hist[k] == {D{~m_db[k]}}) m_db[k] = ~m_db[k];
      end
      m_raw2 = m_raw1;
      m_raw1 = key_n;
    end
    e_buttons = m_emit_now ? m_emit_code : 4'h0;
    e_valid   = m_emit_now;
    e_busy    = m_collecting || m_aborted;
  end

  // every cycle: DUT against model, plus event counters for the sequences
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (buttons !== e_buttons || code_valid !== e_valid || busy !== e_busy || key_db !== m_db) begin
        miscompares++;
        $display("FAIL model t=%0t got buttons=%h valid=%b busy=%b key_db=%b want %h %b %b %b",
                 $time, buttons, code_valid, busy, key_db, e_buttons, e_valid, e_busy, m_db);
      end
      if (code_valid === 1'b1) begin npulse++; last_code = buttons; end
      if (key_db[1] === 1'b1 && !prev_db1) rise1++;
      prev_db1 = (key_db[1] === 1'b1);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    int         hold;
    logic [3:0] code;
    int         n;
  } vec_t;

  vec_t tbl [7];
  int base, rbase, waited;

  initial begin
    tbl[0] = '{4'b0001, 20, 4'h1, 1};
    tbl[1] = '{4'b0010, 15, 4'h2, 1};
    tbl[2] = '{4'b1000,  3, 4'h0, 0};
    tbl[3] = '{4'b0101, 12, 4'h5, 1};
    tbl[4] = '{4'b1111, 10, 4'hF, 1};
    tbl[5] = '{4'b0110, 30, 4'h6, 1};
    tbl[6] = '{4'b0100,  5, 4'h4, 1};

    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_outputs", {buttons, code_valid, busy, key_db}, 0);
    tick(2);

    // table-driven chords
    for (int i = 0; i < 7; i++) begin
      base = npulse;
      key_n = ~tbl[i].mask;
      tick(tbl[i].hold);
      key_n = 4'hF;
      tick(20);
      chk($sformatf("tbl%0d_pulses", i), npulse - base, tbl[i].n);
      if (tbl[i].n != 0) chk($sformatf("tbl%0d_code", i), last_code, tbl[i].code);
      chk($sformatf("tbl%0d_busy", i), busy, 0);
    end

    // 1: strobe lands exactly one cycle after key_db[0] falls
    base = npulse;
    key_n[0] = 1'b0;
    tick(20);
    chk("t1_db_high", key_db[0], 1);
    key_n[0] = 1'b1;
    waited = 0;
    while (key_db[0] !== 1'b0 && waited < 20) begin tick(); waited++; end
    chk("t1_db_fell", (waited < 20) ? 1 : 0, 1);
    chk("t1_valid_at_fall", code_valid, 0);
    tick();
    chk("t1_valid_next", code_valid, 1);
    chk("t1_code_next", buttons, 4'h1);
    tick();
    chk("t1_valid_gone", code_valid, 0);
    tick(10);
    chk("t1_pulses", npulse - base, 1);

    // 2: bouncing key followed by a clean press
    base = npulse; rbase = rise1;
    for (int i = 0; i < 6; i++) begin key_n[1] = ~key_n[1]; tick(2); end
    key_n[1] = 1'b0;
    tick(20);
    key_n[1] = 1'b1;
    tick(20);
    chk("t2_rises", rise1 - rbase, 1);
    chk("t2_pulses", npulse - base, 1);
    chk("t2_code", last_code, 4'h2);

    // 3: staggered three-key chord gives mute
    base = npulse;
    key_n[0] = 1'b0; tick(5);
    key_n[1] = 1'b0; tick(5);
    key_n[2] = 1'b0; tick(5);
    key_n[0] = 1'b1; tick(5);
    key_n[1] = 1'b1; tick(5);
    key_n[2] = 1'b1; tick(20);
    chk("t3_pulses", npulse - base, 1);
    chk("t3_code", last_code, CODE_MUTE);

    // 4: short glitch is rejected outright
    base = npulse;
    key_n[3] = 1'b0; tick(3);
    key_n[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_quiet", {key_db, busy, code_valid}, 0);
      tick();
    end
    chk("t4_pulses", npulse - base, 0);

    // 5: reset mid-chord discards it; held key starts a fresh chord
    key_n[3] = 1'b0;
    tick(8);
    chk("t5_busy_before", busy, 1);
    base = npulse;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_after_reset", {buttons, code_valid, busy, key_db}, 0);
    tick(10);
    key_n[3] = 1'b1;
    tick(20);
    chk("t5_pulses", npulse - base, 1);
    chk("t5_code", last_code, 4'h8);

    // 6: very long hold
    base = npulse;
    key_n[2] = 1'b0; tick(100);
    key_n[2] = 1'b1; tick(20);
    chk("t6_busy", busy, 0);
    if (TMO_EN) begin
      chk("t6_pulses", npulse - base, 0);
    end else begin
      chk("t6_pulses", npulse - base, 1);
      chk("t6_code", last_code, 4'h4);
    end

    // randomized keys with occasional resets, checked by the model
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    key_n = 4'hF;
    tick(30);
    chk("rand_idle", {buttons, code_valid, busy, key_db}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
